add_sub_seq_ctrl: RTL

//  Multi-precision add/subtract sequencer. Accepts W = 4*NIBBLES-bit operands over a valid/ready

---
 rtl/add_sub_seq_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/add_sub_seq_ctrl.sv
// Multi-precision add/subtract sequencer: one shared 4-bit slice walks the operands
// LSB nibble first, with the carry registered between nibbles.
module add_sub_seq_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [4*NIBBLES-1:0]   op_a,
   input  logic [4*NIBBLES-1:0]   op_b,
   input  logic                   sub,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [4*NIBBLES-1:0]   result,
   output logic                   cout,
   output logic                   ovf,
   output logic                   busy
);

   localparam int W     = 4 * NIBBLES;
   localparam int IDX_W = $clog2(NIBBLES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [W-1:0]       a_q, b_q, result_q;
   logic               sub_q, carry_q, cout_q, ovf_q;
   logic [IDX_W-1:0]   idx_q;
   logic               accept, last_nib;
   logic [3:0]         nib_a, nib_b;
   logic [5:0]         slice_o;

   // Returns {carry into bit 3, carry out, 4-bit sum}; the bit-3 carry feeds overflow.
   function automatic logic [5:0] addsub_slice(input logic [3:0] a,
                                               input logic [3:0] b,
                                               input logic       inv,
                                               input logic       cin);
      logic [3:0] bx;
      logic [3:0] lo;
      logic [4:0] full;
      bx   = b ^ {4{inv}};
      lo   = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
      full = {1'b0, a} + {1'b0, bx} + {4'b0000, cin};
      return {lo[3], full};
   endfunction

   assign nib_a    = a_q[{idx_q, 2'b00} +: 4];
   assign nib_b    = b_q[{idx_q, 2'b00} +: 4];
   assign slice_o  = addsub_slice(nib_a, nib_b, sub_q, carry_q);
   assign last_nib = (idx_q == LAST_IDX);

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b1;
      accept    = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            busy     = 1'b0;
            if (in_valid) begin
               accept  = 1'b1;
               state_d = RUN;
            end
         end
         RUN: begin
            if (last_nib) state_d = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Operand capture at accept, then one nibble per cycle while running
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q      <= '0;
         b_q      <= '0;
         sub_q    <= 1'b0;
         carry_q  <= 1'b0;
         idx_q    <= '0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovf_q    <= 1'b0;
      end else if (accept) begin
         a_q     <= op_a;
         b_q     <= op_b;
         sub_q   <= sub;
         carry_q <= sub;
         idx_q   <= '0;
      end else if (state_q == RUN) begin
         result_q[{idx_q, 2'b00} +: 4] <= slice_o[3:0];
         carry_q <= slice_o[4];
         if (last_nib) begin
            cout_q <= slice_o[4];
            ovf_q  <= slice_o[4] ^ slice_o[5];
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end
   end

   assign result = result_q;
   assign cout   = cout_q;
   assign ovf    = ovf_q;

endmodule
